// File: rtl/signed_7seg_scanner.sv
// signed_7seg_scanner: multiplexed signed BCD display driver.
// The leftmost digit shows the sign, the rest show BCD magnitude nibbles.
// New values are held in a shadow register until the end of a scan frame,
// so a frame never mixes old and new digits.
// Optional build macro: LEADING_ZERO_BLANK_EN (blanks leading zero digits).
module signed_7seg_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load,
    input  logic [4*(NUM_DIGITS-1)-1:0] value_bcd,
    input  logic                        sign,
    output logic [6:0]                  segment,
    output logic [NUM_DIGITS-1:0]       anode,
    output logic                        upd_pending
);

    localparam int MAG_W = 4 * (NUM_DIGITS - 1);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b1111110;
    localparam logic [6:0] SEG_ERR   = 7'b0110000;

    logic [CNT_W-1:0]      cnt_q,         cnt_d;
    logic [IDX_W-1:0]      idx_q,         idx_d;
    logic [MAG_W-1:0]      shadow_mag_q,  shadow_mag_d;
    logic                  shadow_sign_q, shadow_sign_d;
    logic [MAG_W-1:0]      disp_mag_q,    disp_mag_d;
    logic                  disp_sign_q,   disp_sign_d;
    logic                  pend_q,        pend_d;
    logic [6:0]            seg_q,         seg_d;
    logic [NUM_DIGITS-1:0] anode_q,       anode_d;

    logic tick;
    logic commit;

    // Active-low 7-segment decode {a,b,c,d,e,f,g}; non-BCD nibbles show 'E'.
    function automatic logic [6:0] decode_bcd(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = SEG_ERR;
        endcase
        return s;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // True when digit pos and every magnitude digit above it are zero.
    function automatic logic is_leading_zero(input logic [MAG_W-1:0] mag,
                                             input int              pos);
        logic zero;
        zero = 1'b1;
        for (int j = 0; j < NUM_DIGITS - 1; j++) begin
            if (j >= pos && mag[4*j +: 4] != 4'd0) begin
                zero = 1'b0;
            end
        end
        return zero;
    endfunction
`endif

    assign tick   = (cnt_q == CNT_MAX);
    assign commit = tick && (idx_q == IDX_MAX) && pend_q;

    // Scan timing: dwell counter and digit index.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (tick) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Shadow capture on load; display update only at the frame boundary.
    always_comb begin
        shadow_mag_d  = shadow_mag_q;
        shadow_sign_d = shadow_sign_q;
        disp_mag_d    = disp_mag_q;
        disp_sign_d   = disp_sign_q;
        pend_d        = pend_q;
        if (commit) begin
            disp_mag_d  = shadow_mag_q;
            disp_sign_d = shadow_sign_q;
            pend_d      = 1'b0;
        end
        if (load) begin
            shadow_mag_d  = value_bcd;
            shadow_sign_d = sign;
            pend_d        = 1'b1;
        end
    end

    // Output pattern for the digit currently selected by idx_q.
    always_comb begin
        seg_d   = SEG_BLANK;
        anode_d = ~(NUM_DIGITS'(1) << idx_q);
        if (idx_q == IDX_MAX) begin
            seg_d = disp_sign_q ? SEG_MINUS : SEG_BLANK;
        end else begin
            for (int i = 0; i < NUM_DIGITS - 1; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    seg_d = decode_bcd(disp_mag_q[4*i +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
                    if (i != 0 && is_leading_zero(disp_mag_q, i)) begin
                        seg_d = SEG_BLANK;
                    end
`endif
                end
            end
        end
    end

    // State and registered outputs; reset clears everything including data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            shadow_mag_q  <= '0;
            shadow_sign_q <= 1'b0;
            disp_mag_q    <= '0;
            disp_sign_q   <= 1'b0;
            pend_q        <= 1'b0;
            seg_q         <= SEG_BLANK;
            anode_q       <= '1;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadow_mag_q  <= shadow_mag_d;
            shadow_sign_q <= shadow_sign_d;
            disp_mag_q    <= disp_mag_d;
            disp_sign_q   <= disp_sign_d;
            pend_q        <= pend_d;
            seg_q         <= seg_d;
            anode_q       <= anode_d;
        end
    end

    assign segment     = seg_q;
    assign anode       = anode_q;
    assign upd_pending = pend_q;

endmodule

// File: tb/tb_signed_7seg_scanner.sv
// Directed testbench for signed_7seg_scanner (NUM_DIGITS=4, REFRESH_DIV=4).
// Honors LEADING_ZERO_BLANK_EN when the bench is built with the macro.
module tb_signed_7seg_scanner;

    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100;
    localparam logic [6:0] S6 = 7'b0100000, S7 = 7'b0001111, S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0000100, SE = 7'b0110000;
    localparam logic [6:0] SM = 7'b1111110, SB = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] SLZ = SB;
`else
    localparam logic [6:0] SLZ = S0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic        sign = 1'b0;
    logic [11:0] value_bcd = 12'h000;
    logic [6:0]  segment;
    logic [3:0]  anode;
    logic        upd_pending;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    signed_7seg_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value_bcd  (value_bcd),
        .sign       (sign),
        .segment    (segment),
        .anode      (anode),
        .upd_pending(upd_pending)
    );

    always #5 clk = ~clk;

    // One rising edge, then park on the falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        n_checks++;
        if (anode !== 4'b1111) begin
            n_fail++; $display("FAIL reset_anode: got %b expected 1111", anode);
        end
        n_checks++;
        if (segment !== SB) begin
            n_fail++; $display("FAIL reset_segment: got %b expected %b", segment, SB);
        end
        n_checks++;
        if (upd_pending !== 1'b0) begin
            n_fail++; $display("FAIL reset_pending: got %b expected 0", upd_pending);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        logic [6:0] exp [4];
        int d;
        exp = '{S0, SLZ, SLZ, SB};
        for (int k = 1; k <= 16; k++) begin
            step();
            d = (k - 1) / 4;
            n_checks++;
            if (anode !== an_tab[d]) begin
                n_fail++; $display("FAIL scan_anode k=%0d: got %b expected %b", k, anode, an_tab[d]);
            end
            n_checks++;
            if (segment !== exp[d]) begin
                n_fail++; $display("FAIL scan_segment k=%0d: got %b expected %b", k, segment, exp[d]);
            end
        end
    endtask

    task automatic test_load_commit();
        logic [6:0] exp [4];
        int d;
        for (int f = 0; f < 2; f++) begin
            if (f == 0) exp = '{S0, SLZ, SLZ, SB};
            else        exp = '{S3, S2, S1, SM};
            for (int k = 1; k <= 16; k++) begin
                if (f == 0 && k == 7) begin
                    load = 1'b1; value_bcd = 12'h123; sign = 1'b1;
                end
                step();
                load = 1'b0;
                d = (k - 1) / 4;
                n_checks++;
                if (anode !== an_tab[d]) begin
                    n_fail++; $display("FAIL commit_anode f=%0d k=%0d: got %b expected %b", f, k, anode, an_tab[d]);
                end
                n_checks++;
                if (segment !== exp[d]) begin
                    n_fail++; $display("FAIL commit_segment f=%0d k=%0d: got %b expected %b", f, k, segment, exp[d]);
                end
                if (f == 0 && (k == 7 || k == 15)) begin
                    n_checks++;
                    if (upd_pending !== 1'b1) begin
                        n_fail++; $display("FAIL commit_pending_set k=%0d: got %b expected 1", k, upd_pending);
                    end
                end
                if (f == 0 && k == 16) begin
                    n_checks++;
                    if (upd_pending !== 1'b0) begin
                        n_fail++; $display("FAIL commit_pending_clr: got %b expected 0", upd_pending);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp [4];
        int d;
        for (int f = 0; f < 2; f++) begin
            if (f == 0) exp = '{S3, S2, S1, SM};
            else        exp = '{S2, S2, S2, SB};
            for (int k = 1; k <= 16; k++) begin
                if (f == 0 && k == 3) begin
                    load = 1'b1; value_bcd = 12'h111; sign = 1'b0;
                end
                if (f == 0 && k == 6) begin
                    load = 1'b1; value_bcd = 12'h222; sign = 1'b0;
                end
                step();
                load = 1'b0;
                d = (k - 1) / 4;
                n_checks++;
                if (segment !== exp[d]) begin
                    n_fail++; $display("FAIL b2b_segment f=%0d k=%0d: got %b expected %b", f, k, segment, exp[d]);
                end
                if (f == 0 && k == 3) begin
                    n_checks++;
                    if (upd_pending !== 1'b1) begin
                        n_fail++; $display("FAIL b2b_pending: got %b expected 1", upd_pending);
                    end
                end
            end
        end
    endtask

    task automatic test_error_digit();
        logic [6:0] exp [4];
        int d;
        for (int f = 0; f < 2; f++) begin
            if (f == 0) exp = '{S2, S2, S2, SB};
            else        exp = '{S5, SE, SLZ, SB};
            for (int k = 1; k <= 16; k++) begin
                if (f == 0 && k == 1) begin
                    load = 1'b1; value_bcd = 12'h0A5; sign = 1'b0;
                end
                step();
                load = 1'b0;
                d = (k - 1) / 4;
                n_checks++;
                if (segment !== exp[d]) begin
                    n_fail++; $display("FAIL error_segment f=%0d k=%0d: got %b expected %b", f, k, segment, exp[d]);
                end
            end
        end
    endtask

    task automatic test_load_at_commit();
        logic [6:0] exp [4];
        int d;
        for (int f = 0; f < 3; f++) begin
            if (f == 0)      exp = '{S5, SE, SLZ, SB};
            else if (f == 1) exp = '{S9, S8, S7, SB};
            else             exp = '{S6, S5, S4, SM};
            for (int k = 1; k <= 16; k++) begin
                if (f == 0 && k == 2) begin
                    load = 1'b1; value_bcd = 12'h789; sign = 1'b0;
                end
                if (f == 0 && k == 16) begin
                    load = 1'b1; value_bcd = 12'h456; sign = 1'b1;
                end
                step();
                load = 1'b0;
                d = (k - 1) / 4;
                n_checks++;
                if (segment !== exp[d]) begin
                    n_fail++; $display("FAIL collide_segment f=%0d k=%0d: got %b expected %b", f, k, segment, exp[d]);
                end
                if ((f == 0 && k == 16) || (f == 1 && k == 8)) begin
                    n_checks++;
                    if (upd_pending !== 1'b1) begin
                        n_fail++; $display("FAIL collide_pending_kept f=%0d k=%0d: got %b expected 1", f, k, upd_pending);
                    end
                end
                if (f == 1 && k == 16) begin
                    n_checks++;
                    if (upd_pending !== 1'b0) begin
                        n_fail++; $display("FAIL collide_pending_clr: got %b expected 0", upd_pending);
                    end
                end
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [6:0] exp [4];
        int d;
        for (int f = 0; f < 2; f++) begin
            if (f == 0) exp = '{S6, S5, S4, SM};
            else        exp = '{S7, SLZ, SLZ, SB};
            for (int k = 1; k <= 16; k++) begin
                if (f == 0 && k == 1) begin
                    load = 1'b1; value_bcd = 12'h007; sign = 1'b0;
                end
                step();
                load = 1'b0;
                d = (k - 1) / 4;
                n_checks++;
                if (segment !== exp[d]) begin
                    n_fail++; $display("FAIL lzero_segment f=%0d k=%0d: got %b expected %b", f, k, segment, exp[d]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [6:0] exp [4];
        int d;
        exp = '{S7, SLZ, SLZ, SB};
        for (int k = 1; k <= 9; k++) begin
            if (k == 2) begin
                load = 1'b1; value_bcd = 12'h555; sign = 1'b1;
            end
            step();
            load = 1'b0;
            d = (k - 1) / 4;
            n_checks++;
            if (segment !== exp[d]) begin
                n_fail++; $display("FAIL rmid_pre_segment k=%0d: got %b expected %b", k, segment, exp[d]);
            end
        end
        n_checks++;
        if (upd_pending !== 1'b1) begin
            n_fail++; $display("FAIL rmid_pre_pending: got %b expected 1", upd_pending);
        end
        rst_n = 1'b0;
        step();
        n_checks++;
        if (anode !== 4'b1111) begin
            n_fail++; $display("FAIL rmid_anode: got %b expected 1111", anode);
        end
        n_checks++;
        if (segment !== SB) begin
            n_fail++; $display("FAIL rmid_segment: got %b expected %b", segment, SB);
        end
        n_checks++;
        if (upd_pending !== 1'b0) begin
            n_fail++; $display("FAIL rmid_pending: got %b expected 0", upd_pending);
        end
        rst_n = 1'b1;
        exp = '{S0, SLZ, SLZ, SB};
        for (int k = 1; k <= 16; k++) begin
            step();
            d = (k - 1) / 4;
            n_checks++;
            if (anode !== an_tab[d]) begin
                n_fail++; $display("FAIL rmid_post_anode k=%0d: got %b expected %b", k, anode, an_tab[d]);
            end
            n_checks++;
            if (segment !== exp[d]) begin
                n_fail++; $display("FAIL rmid_post_segment k=%0d: got %b expected %b", k, segment, exp[d]);
            end
        end
        n_checks++;
        if (upd_pending !== 1'b0) begin
            n_fail++; $display("FAIL rmid_post_pending: got %b expected 0", upd_pending);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_scan();
        test_load_commit();
        test_back_to_back();
        test_error_digit();
        test_load_at_commit();
        test_leading_zero();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/signed_7seg_scanner.md
SIGNED_7SEG_SCANNER -- requirements
Module: signed_7seg_scanner

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, meaning the total digit count including the sign digit (range 2..8).
REQ-002 The block SHALL have parameter REFRESH_DIV, default 100000, meaning clock cycles per digit dwell (range 2..2^20).
REQ-003 Port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port load, input, 1 bit: capture strobe for value_bcd and sign.
REQ-006 Port value_bcd, input, 4*(NUM_DIGITS-1) bits: magnitude as BCD nibbles, nibble 0 least significant.
REQ-007 Port sign, input, 1 bit: 1 = negative.
REQ-008 Port segment, output, 7 bits, active-low: bit order {a,b,c,d,e,f,g} = segment[6:0].
REQ-009 Port anode, output, NUM_DIGITS bits, active-low: one-hot digit enable; bit i drives digit i.
REQ-010 Port upd_pending, output, 1 bit: high while a captured value awaits its frame-boundary commit.

Function
REQ-011 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; tick = (counter == REFRESH_DIV-1).
REQ-012 The digit index idx SHALL advance on tick, wrapping from NUM_DIGITS-1 to 0; frame = NUM_DIGITS*REFRESH_DIV cycles.
REQ-013 anode and segment SHALL be registered, reflecting the current idx with exactly 1 cycle latency.
REQ-014 anode SHALL be all ones except bit idx = 0; exactly one bit is low at any time outside reset.
REQ-015 Digit NUM_DIGITS-1 (leftmost) SHALL show the sign: minus = 7'b1111110 when sign is 1, blank = 7'b1111111 when 0.
REQ-016 Digits 0..NUM_DIGITS-2 SHALL decode the committed nibbles 0-9 to the standard active-low patterns (0 = 7'b0000001, 8 = 7'b0000000).
REQ-017 A nibble >9 SHALL display 'E' = 7'b0110000.
REQ-018 load=1 SHALL capture value_bcd and sign into a shadow register on that edge and set upd_pending the next cycle.
REQ-019 Shadow-to-display commit SHALL occur only on the cycle where tick=1 and idx=NUM_DIGITS-1, when upd_pending=1; upd_pending clears on the same edge.
REQ-020 Back-to-back loads before a commit SHALL overwrite the shadow; only the last value is committed.
REQ-021 A load coinciding with a commit SHALL commit the older shadow, capture the new data and leave upd_pending=1.
REQ-022 The displayed value SHALL never change mid-frame (no tearing).

Reset
REQ-023 While rst_n=0 at a clock edge: counter=0, idx=0, shadow and display registers=0, sign registers=0, upd_pending=0.
REQ-024 After the reset edge, segment SHALL be 7'b1111111 and anode all ones until one cycle after rst_n returns high.
REQ-025 Reset asserted mid-frame or with upd_pending=1 SHALL discard pending data; scanning resumes from idx=0.

Configuration
REQ-026 Macro LEADING_ZERO_BLANK_EN: when defined, magnitude digits above the most significant non-zero digit SHALL show blank, and digit 0 always shows its value; the sign digit is unaffected.
REQ-027 When LEADING_ZERO_BLANK_EN is undefined, all magnitude digits SHALL display their decoded nibble, including leading zeros.

Verification (NUM_DIGITS=4, REFRESH_DIV=4)
REQ-028 Reset, release, run 16 cycles -> anode sequence 1110,1101,1011,0111, each held 4 cycles; segment 7'b0000001 on digits 0-2, 7'b1111111 on digit 3.
REQ-029 load with value_bcd=12'h123, sign=1 at mid-frame -> upd_pending=1 until the idx=3 tick; the next frame shows 3,2,1 then minus 7'b1111110.
REQ-030 Two loads 12'h111 then 12'h222 inside one frame -> only 222 is displayed; 111 never appears.
REQ-031 value_bcd=12'h0A5 -> digit 1 shows 7'b0110000 ('E').
REQ-032 With LEADING_ZERO_BLANK_EN, value_bcd=12'h007 -> digits 1,2 = 7'b1111111, digit 0 = 7'b0001111; without the macro digits 1,2 = 7'b0000001.
REQ-033 rst_n low for 1 cycle with upd_pending=1 at idx=2 -> outputs all ones, upd_pending=0, restart at anode=1110 showing 000 with blank sign.
